// File: rtl/vend_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vend_pkg : coin codes, coin values and dispenser state encoding (rev 1.0)
// ---------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  localparam int unsigned ONE_VALUE = 1;
  localparam int unsigned TWO_VALUE = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EMIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } disp_state_t;

  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_ONE: coin_value = ONE_VALUE;
      COIN_TWO: coin_value = TWO_VALUE;
      default:  coin_value = 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// change_dispenser : greedy largest-first coin return on the 2-bit coin bus (rev 1.0)
// ---------------------------------------------------------------------------
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 4,
  parameter int STOCK_W    = 6,
  parameter int INIT_ONE   = 8,
  parameter int INIT_TWO   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amount,
  output logic               req_ready,
  input  logic               refill,
  output logic [1:0]         coin,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [STOCK_W-1:0] stock_one,
  output logic [STOCK_W-1:0] stock_two
);

  disp_state_t        r_state;
  disp_state_t        w_next;
  logic [AMT_W-1:0]   r_rem;
  logic [STOCK_W-1:0] r_stock_one;
  logic [STOCK_W-1:0] r_stock_two;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel;
  logic               r_short;
  logic               w_short;
  logic [3:0]         r_gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_sel   = COIN_NONE;
    w_short = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        // A coin is only chosen when its stock is nonzero, so stocks cannot underflow
        if (r_rem >= AMT_W'(TWO_VALUE) && r_stock_two != '0) begin
          w_sel  = COIN_TWO;
          w_next = ST_EMIT;
        end else if (r_rem != '0 && r_stock_one != '0) begin
          w_sel  = COIN_ONE;
          w_next = ST_EMIT;
        end else begin
          w_short = (r_rem != '0);
          w_next  = ST_DONE;
        end
      end
      ST_EMIT: w_next = (GAP_CYCLES > 0) ? ST_GAP : ST_CHECK;
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) w_next = ST_CHECK;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_sel       <= COIN_NONE;
      r_short     <= 1'b0;
      r_gap_cnt   <= 4'd0;
      r_stock_one <= STOCK_W'(INIT_ONE);
      r_stock_two <= STOCK_W'(INIT_TWO);
    end else begin
      if (r_state == ST_IDLE && req_valid) r_rem <= req_amount;
      if (r_state == ST_CHECK) begin
        r_sel   <= w_sel;
        r_short <= w_short;
      end
      if (r_state == ST_EMIT) begin
        r_rem     <= r_rem - AMT_W'(coin_value(r_sel));
        r_gap_cnt <= 4'(GAP_CYCLES - 1);
      end else if (r_state == ST_GAP && r_gap_cnt != 4'd0) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end
      // Refill wins over a coincident EMIT decrement
      if (refill) begin
        r_stock_one <= STOCK_W'(INIT_ONE);
        r_stock_two <= STOCK_W'(INIT_TWO);
      end else if (r_state == ST_EMIT) begin
        if (r_sel == COIN_TWO)      r_stock_two <= r_stock_two - STOCK_W'(1);
        else if (r_sel == COIN_ONE) r_stock_one <= r_stock_one - STOCK_W'(1);
      end
    end
  end

  assign coin      = (r_state == ST_EMIT) ? r_sel : COIN_NONE;
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign short     = (r_state == ST_DONE) && r_short;
  assign stock_one = r_stock_one;
  assign stock_two = r_stock_two;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_change_dispenser : vector table, corner sequences and random model check (rev 1.0)
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int GAP    = 1;
  localparam int PERIOD = 2 + GAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, refill, req_valid, sel;
  logic [3:0] req_amount;
  logic       rv_a, rv_b;
  logic       ready_a, busy_a, done_a, short_a, ready_b, busy_b, done_b, short_b;
  logic [1:0] coin_a, coin_b;
  logic [5:0] s1_a, s2_a, s1_b, s2_b;
  logic       ready_m, busy_m, done_m, short_m;
  logic [1:0] coin_m;
  logic [5:0] s1_m, s2_m;

  assign rv_a    = req_valid & ~sel;
  assign rv_b    = req_valid & sel;
  assign ready_m = sel ? ready_b : ready_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign short_m = sel ? short_b : short_a;
  assign coin_m  = sel ? coin_b  : coin_a;
  assign s1_m    = sel ? s1_b    : s1_a;
  assign s2_m    = sel ? s2_b    : s2_a;

  change_dispenser #(.AMT_W(4), .STOCK_W(6), .INIT_ONE(8), .INIT_TWO(8), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_amount(req_amount), .req_ready(ready_a),
    .refill(refill), .coin(coin_a), .busy(busy_a), .done(done_a), .short(short_a),
    .stock_one(s1_a), .stock_two(s2_a));

  change_dispenser #(.AMT_W(4), .STOCK_W(6), .INIT_ONE(1), .INIT_TWO(0), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_amount(req_amount), .req_ready(ready_b),
    .refill(refill), .coin(coin_b), .busy(busy_b), .done(done_b), .short(short_b),
    .stock_one(s1_b), .stock_two(s2_b));

  int checks   = 0;
  int failures = 0;
  int m_s1[2];
  int m_s2[2];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_refill();
    m_s1[0] = 8; m_s2[0] = 8;
    m_s1[1] = 1; m_s2[1] = 0;
  endtask

  // Greedy payout from the amount and the modelled stocks
  task automatic model_pay(input bit w, input int amt, output int n2, output int n1,
                           output int sh, output int lat);
    int r;
    n2 = (amt / 2 < m_s2[w]) ? amt / 2 : m_s2[w];
    r  = amt - 2 * n2;
    n1 = (r < m_s1[w]) ? r : m_s1[w];
    sh = ((r - n1) != 0) ? 1 : 0;
    lat = 2 + (n2 + n1) * PERIOD;
    m_s2[w] -= n2;
    m_s1[w] -= n1;
  endtask

  task automatic pulse_refill();
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
  endtask

  task automatic run_req(input bit which, input int amt, output int twos, output int ones,
                         output int shrt, output int lat, output int rdy, output int seq_err);
    int prev, ncoin;
    twos = 0; ones = 0; shrt = -1; lat = -1; rdy = -1; seq_err = 0; prev = 0; ncoin = 0;
    @(negedge clk);
    sel = which; req_amount = 4'(amt); req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (coin_m != 2'b00) begin
        if (coin_m == 2'b10) begin
          twos++;
          if (ones > 0) seq_err++;
        end else if (coin_m == 2'b01) ones++;
        else seq_err++;
        if (n != 2 + ncoin * PERIOD) seq_err++;
        if (prev != 0) seq_err++;
        ncoin++;
      end
      prev = int'(coin_m);
      if (done_m) begin
        lat = n; shrt = int'(short_m);
        @(negedge clk);
        rdy = int'(ready_m);
        break;
      end
    end
  endtask

  typedef struct {
    bit which; int amt; bit refill_first;
    int twos; int ones; int shrt; int lat; int s1; int s2;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int twos, ones, shrt, lat, rdy, serr;
    int e2, e1, esh, elat;
    int ncoins, c1, c2, nrdy, rdyc, ndone, adj, prev;
    bit w;
    int amt;

    rst = 1'b1; refill = 1'b0; req_valid = 1'b0; sel = 1'b0; req_amount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_refill();
    check("rst_coin", int'(coin_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_short", int'(short_a), 0);
    check("rst_ready", int'(ready_a), 1);
    check("rst_s1_a", int'(s1_a), 8);
    check("rst_s2_a", int'(s2_a), 8);
    check("rst_s1_b", int'(s1_b), 1);
    check("rst_s2_b", int'(s2_b), 0);

    vecs[0] = '{1'b0, 5,  1'b0, 2, 1, 0, 11, 7, 6};
    vecs[1] = '{1'b1, 3,  1'b0, 0, 1, 1, 5,  0, 0};
    vecs[2] = '{1'b0, 0,  1'b0, 0, 0, 0, 2,  7, 6};
    vecs[3] = '{1'b1, 2,  1'b0, 0, 0, 1, 2,  0, 0};
    vecs[4] = '{1'b0, 15, 1'b0, 6, 3, 0, 29, 4, 0};
    vecs[5] = '{1'b0, 3,  1'b0, 0, 3, 0, 11, 1, 0};
    vecs[6] = '{1'b0, 4,  1'b0, 0, 1, 1, 5,  0, 0};
    vecs[7] = '{1'b0, 4,  1'b1, 2, 0, 0, 8,  8, 6};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].refill_first) pulse_refill();
      run_req(vecs[i].which, vecs[i].amt, twos, ones, shrt, lat, rdy, serr);
      model_pay(vecs[i].which, vecs[i].amt, e2, e1, esh, elat);
      check($sformatf("vec%0d_twos", i), twos, vecs[i].twos);
      check($sformatf("vec%0d_ones", i), ones, vecs[i].ones);
      check($sformatf("vec%0d_short", i), shrt, vecs[i].shrt);
      check($sformatf("vec%0d_done_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_ready_after", i), rdy, 1);
      check($sformatf("vec%0d_coin_seq", i), serr, 0);
      check($sformatf("vec%0d_stock_one", i), int'(s1_m), vecs[i].s1);
      check($sformatf("vec%0d_stock_two", i), int'(s2_m), vecs[i].s2);
    end

    // Reset during the first EMIT of a 5-unit request
    @(negedge clk); sel = 1'b0; req_amount = 4'd5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("rstemit_coin_before", int'(coin_a), 2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_refill();
    check("rstemit_coin", int'(coin_a), 0);
    check("rstemit_busy", int'(busy_a), 0);
    check("rstemit_ready", int'(ready_a), 1);
    check("rstemit_s1", int'(s1_a), 8);
    check("rstemit_s2", int'(s2_a), 8);
    ncoins = 0; ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (coin_a != 2'b00) ncoins++;
      if (done_a) ndone++;
    end
    check("rstemit_no_coins", ncoins, 0);
    check("rstemit_no_done", ndone, 0);

    // Refill coincident with an EMIT of a two-unit coin
    @(negedge clk); sel = 1'b0; req_amount = 4'd2; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("refemit_coin", int'(coin_a), 2);
    refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
    check("refemit_s2", int'(s2_a), 8);
    lat = -1;
    for (int n = 3; n < 40; n++) begin
      if (done_a) begin lat = n; shrt = int'(short_a); break; end
      @(negedge clk);
    end
    check("refemit_done_lat", lat, 5);
    check("refemit_short", shrt, 0);
    check("refemit_s2_end", int'(s2_a), 8);

    // req_valid held high across two back-to-back requests of 2
    @(negedge clk); sel = 1'b0; req_amount = 4'd2; req_valid = 1'b1;
    @(posedge clk);
    ncoins = 0; c1 = -1; c2 = -1; nrdy = 0; rdyc = -1; ndone = 0; adj = 0; prev = 0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (coin_a != 2'b00) begin
        if (ncoins == 0) c1 = n; else if (ncoins == 1) c2 = n;
        ncoins++;
        if (prev != 0) adj++;
      end
      prev = int'(coin_a);
      if (ready_a) begin nrdy++; rdyc = n; end
      if (done_a) ndone++;
    end
    req_valid = 1'b0;
    model_pay(1'b0, 2, e2, e1, esh, elat);
    model_pay(1'b0, 2, e2, e1, esh, elat);
    check("held_coin_count", ncoins, 2);
    check("held_first_coin", c1, 2);
    check("held_second_coin", c2, 8);
    check("held_ready_count", nrdy, 1);
    check("held_ready_cycle", rdyc, 6);
    check("held_done_count", ndone, 2);
    check("held_adjacent", adj, 0);
    @(negedge clk);

    // Randomized requests against the greedy model
    pulse_refill();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_refill();
      amt = int'($urandom_range(0, 15));
      w   = ($urandom_range(0, 4) == 0);
      run_req(w, amt, twos, ones, shrt, lat, rdy, serr);
      model_pay(w, amt, e2, e1, esh, elat);
      check($sformatf("rnd%0d_twos", i), twos, e2);
      check($sformatf("rnd%0d_ones", i), ones, e1);
      check($sformatf("rnd%0d_short", i), shrt, esh);
      check($sformatf("rnd%0d_done_lat", i), lat, elat);
      check($sformatf("rnd%0d_ready_after", i), rdy, 1);
      check($sformatf("rnd%0d_coin_seq", i), serr, 0);
      check($sformatf("rnd%0d_stock_one", i), int'(s1_m), m_s1[w]);
      check($sformatf("rnd%0d_stock_two", i), int'(s2_m), m_s2[w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
